// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes, opcodes, loader states.
package instr_encoder_loader_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } load_state_e;

    localparam logic [6:0]  OP_OP     = 7'h33;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational packer: decoded fields -> 32-bit RV instruction plus error flag.
// Immediate range checking is compiled in when IMM_RANGE_CHECK_EN is defined.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    output logic [31:0]     instr,
    output logic            err
);

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // True when v is representable as an n-bit two's complement value.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int n);
        logic [XLEN-1:0] s;
        s = $signed(v) >>> (n - 1);
        return (s == '0) || (s == '1);
    endfunction

    logic range_bad;
    logic fmt_bad;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        instr     = NOP_INSTR;
        range_bad = 1'b0;
        fmt_bad   = 1'b0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_bad = !fits_signed(imm, 12);
            end
            FMT_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_bad = !fits_signed(imm, 12);
            end
            FMT_B: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_bad = !fits_signed(imm, 13) || imm[0];
            end
            FMT_U: begin
                instr     = {imm[31:12], rd, opcode};
                range_bad = !fits_signed(imm, 32) || (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_bad = !fits_signed(imm, 21) || imm[0];
            end
            default: fmt_bad = 1'b1;
        endcase
    end

    assign err = fmt_bad | (range_bad & RANGE_EN);

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles into RV instructions and streams them with byte addresses into
// instruction memory until DEPTH words are written. Optional: IMM_RANGE_CHECK_EN.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int              DEPTH     = 16,
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fmt,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_addr,
    output logic            out_err,
    output logic            err_sticky,
    output logic            full
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   LAST_C  = CW'(DEPTH - 1);

    load_state_e   state;
    logic [CW-1:0] issued;   // bundles accepted since reset/restart
    logic [CW-1:0] index;    // words handed to memory since reset/restart
    logic [31:0]   pk_instr;
    logic          pk_err;
    logic          accept;
    logic          out_hs;

    instr_field_packer #(.XLEN(XLEN)) u_packer (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (pk_instr),
        .err    (pk_err)
    );

    assign in_ready = (state == ST_LOAD) & ~restart & (~out_valid | out_ready) & (issued < DEPTH_C);
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            issued     <= '0;
            index      <= '0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= BASE_ADDR;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            full       <= 1'b0;
        end else if (restart) begin
            state      <= ST_LOAD;
            issued     <= '0;
            index      <= '0;
            out_valid  <= 1'b0;
            out_addr   <= BASE_ADDR;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            full       <= 1'b0;
        end else begin
            // The last word keeps its address; the loader stops instead of advancing.
            if (out_hs) begin
                if (index == LAST_C) begin
                    state <= ST_FULL;
                    full  <= 1'b1;
                end else begin
                    index    <= index + 1'b1;
                    out_addr <= out_addr + XLEN'(4);
                end
            end
            if (accept) begin
                out_valid  <= 1'b1;
                out_instr  <= pk_instr;
                out_err    <= pk_err;
                err_sticky <= err_sticky | pk_err;
                issued     <= issued + 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0x1000).
module tb_instr_encoder_loader;

    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h1000;
`ifdef IMM_RANGE_CHECK_EN
    localparam logic        RC = 1'b1;
`else
    localparam logic        RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [63:0] in_imm, out_addr;
    logic [31:0] out_instr;
    logic        out_err, err_sticky, full;

    int checks   = 0;
    int failures = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .XLEN(64), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] imm);
        in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    // Called at a negedge; bundle is accepted on the next posedge, outputs seen at the next negedge.
    task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
        drive(fmt, opc, rd, rs1, rs2, f3, f7, imm);
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; out_ready = 1'b1;
        drive(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_addr", out_addr, BASE);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'd1);

        // I-type addi x1, x0, -1
        send("i_neg1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h7F, -64'sd1);
        check("i_neg1_instr", 64'(out_instr), 64'hFFF0_0093);
        check("i_neg1_addr", out_addr, BASE);
        check("i_neg1_err", 64'(out_err), 64'd0);

        // S-type sw x5, 8(x2); back-to-back with the handshake of the previous word
        send("s_8", 3'd2, 7'h23, 5'd31, 5'd2, 5'd5, 3'd2, 7'h7F, 64'd8);
        check("s_8_instr", 64'(out_instr), 64'h0051_2423);
        check("s_8_addr", out_addr, BASE + 64'd4);

        // B-type beq x0, x0, -4
        send("b_m4", 3'd3, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4);
        check("b_m4_instr", 64'(out_instr), 64'hFE00_0EE3);
        check("b_m4_addr", out_addr, BASE + 64'd8);
        check("b_m4_err", 64'(out_err), 64'd0);

        // B-type odd offset -3: word DEPTH-1
        send("b_m3", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd3);
        check("b_m3_instr", 64'(out_instr), 64'hFE00_0EE3);
        check("b_m3_addr", out_addr, BASE + 64'd12);
        check("b_m3_err", 64'(out_err), 64'(RC));
        check("b_m3_sticky", 64'(err_sticky), 64'(RC));
        check("b_m3_ready", 64'(in_ready), 64'd0);
        check("b_m3_full", 64'(full), 64'd0);

        @(negedge clk);
        check("full_full", 64'(full), 64'd1);
        check("full_valid", 64'(out_valid), 64'd0);
        check("full_addr", out_addr, BASE + 64'd12);

        // Fifth bundle while FULL must be ignored
        drive(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd1);
        #1 check("full_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("full_ignored", 64'(out_valid), 64'd0);

        // Restart out of FULL, with in_valid still high
        restart = 1'b1;
        #1 check("rs_full_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 restart = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rs_full", 64'(full), 64'd0);
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_addr", out_addr, BASE);
        check("rs_sticky", 64'(err_sticky), 64'd0);

        // Restart in LOAD with a simultaneous bundle: restart wins
        restart = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd1);
        #1 check("rs_win_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 restart = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rs_win_valid", 64'(out_valid), 64'd0);

        // I-type imm=2048 out of range: addi x3, x4, 2048
        send("i_2048", 3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd2048);
        check("i_2048_instr", 64'(out_instr), 64'h8002_0193);
        check("i_2048_addr", out_addr, BASE);
        check("i_2048_err", 64'(out_err), 64'(RC));
        check("i_2048_sticky", 64'(err_sticky), 64'(RC));

        // Backpressure: held word stable, new bundle refused
        out_ready = 1'b0;
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_instr", 64'(out_instr), 64'h8002_0193);
            check("bp_addr", out_addr, BASE);
            check("bp_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("u_instr", 64'(out_instr), 64'h1234_52B7);
        check("u_addr", out_addr, BASE + 64'd4);
        check("u_err", 64'(out_err), 64'd0);

        // J-type jal x1, 2048
        send("j_2048", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
        check("j_2048_instr", 64'(out_instr), 64'h0010_00EF);
        check("j_2048_addr", out_addr, BASE + 64'd8);
        check("j_2048_err", 64'(out_err), 64'd0);

        // Illegal format 6 -> NOP with error
        send("ill", 3'd6, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 64'd0);
        check("ill_instr", 64'(out_instr), 64'h0000_0013);
        check("ill_err", 64'(out_err), 64'd1);
        check("ill_sticky", 64'(err_sticky), 64'd1);
        check("ill_addr", out_addr, BASE + 64'd12);
        @(negedge clk);
        check("full2_full", 64'(full), 64'd1);

        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);

        // R-type sub x3, x1, x2 (imm ignored)
        send("r_sub", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, -64'sd1);
        check("r_sub_instr", 64'(out_instr), 64'h4020_81B3);
        check("r_sub_addr", out_addr, BASE);
        check("r_sub_err", 64'(out_err), 64'd0);
        check("r_sub_sticky", 64'(err_sticky), 64'd0);

        // Asynchronous reset while a word is pending
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_instr", 64'(out_instr), 64'd0);
        check("arst_addr", out_addr, BASE);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
